garage_input_conditioner: RTL and testbench

//  Front end for the garage door controller FSM.
//  - Synchronises and debounces the raw push-button and the two raw limit switches.
//  - Drives the clean Up_Max / Dn_Max levels into the FSM.
//  - Turns button presses into a latched run request, Active, which sets and clears on events.
//  - Optionally aborts a run that lasts too long and flags a fault.

---
 rtl/garage_input_conditioner.sv | 155 +++++++++++++++
 tb/tb_garage_input_conditioner.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/garage_input_conditioner.sv
// ---------------------------------------------------------------------------
// garage_input_conditioner
//   Front end for the garage door controller FSM. Synchronises and debounces
//   the raw push-button and both limit switches, presents clean limit levels,
//   and turns button presses into a latched run request (Active).
//
//   Optional feature macro: GARAGE_TIMEOUT_EN
//     defined   -> run-timeout counter and FAULT state are built.
//     undefined -> Fault is tied low; RUN exits only on press or limit edges.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   Btn_Raw    in   raw push-button (async, bouncy)
//   Up_Sw_Raw  in   raw upper limit switch (async, bouncy)
//   Dn_Sw_Raw  in   raw lower limit switch (async, bouncy)
//   Active     out  latched run request
//   Up_Max     out  debounced upper limit level
//   Dn_Max     out  debounced lower limit level
//   Fault      out  run timed out, held until acknowledged by a press
// ---------------------------------------------------------------------------
module garage_input_conditioner #(
    parameter int DB_CYCLES      = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TO_W           = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic Btn_Raw,
    input  logic Up_Sw_Raw,
    input  logic Dn_Sw_Raw,
    output logic Active,
    output logic Up_Max,
    output logic Dn_Max,
    output logic Fault
);

    localparam int NCH = 3;
    localparam int BTN = 0;
    localparam int UP  = 1;
    localparam int DN  = 2;
    localparam int CW  = $clog2(DB_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    logic [NCH-1:0]         raw;
    logic [NCH-1:0]         sync1_q, sync2_q;
    logic [NCH-1:0]         deb_q, deb_prev_q;
    logic [NCH-1:0][CW-1:0] cnt_q;

    assign raw = {Dn_Sw_Raw, Up_Sw_Raw, Btn_Raw};

    // Synchroniser + debounce + edge-detect history, one lane per raw input.
    // A lane's counter only runs while the synced value disagrees with the
    // debounced level; DB_CYCLES consecutive disagreements flip the level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            cnt_q      <= '0;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            deb_prev_q <= deb_q;
            for (int i = 0; i < NCH; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CW'(DB_CYCLES - 1)) begin
                    deb_q[i] <= sync2_q[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // One-cycle events, valid the cycle after the debounced level rises.
    logic press, up_hit, dn_hit, both_lim, exit_ev;
    assign press    = deb_q[BTN] & ~deb_prev_q[BTN];
    assign up_hit   = deb_q[UP]  & ~deb_prev_q[UP];
    assign dn_hit   = deb_q[DN]  & ~deb_prev_q[DN];
    assign both_lim = deb_q[UP]  &  deb_q[DN];
    // Only limit *edges* end a run, so a run launched sitting on a limit
    // keeps going until the opposite limit rises.
    assign exit_ev  = press | up_hit | dn_hit | both_lim;

    state_t state_q, state_d;
    logic   active_q;
    logic   to_hit;

`ifdef GARAGE_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt_q;
    logic            fault_q;

    assign to_hit = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    // Counts cycles spent in RUN; saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset || state_q != RUN) begin
            to_cnt_q <= '0;
        end else if (to_cnt_q != '1) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

    assign Fault = fault_q;
`else
    assign to_hit = 1'b0;
    // Timeout parameters stay in the parameter list so both builds share one
    // instantiation; they have no effect here.
    assign Fault  = 1'b0 & TIMEOUT_CYCLES[0] & TO_W[0];
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (press && !both_lim) state_d = RUN;
            // Exit events take priority over the timeout.
            RUN:     if (exit_ev)            state_d = IDLE;
                     else if (to_hit)        state_d = FAULT;
            // A press in FAULT only acknowledges; it never starts a run.
            FAULT:   if (press)              state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            active_q <= 1'b0;
`ifdef GARAGE_TIMEOUT_EN
            fault_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            active_q <= (state_d == RUN);
`ifdef GARAGE_TIMEOUT_EN
            fault_q  <= (state_d == FAULT);
`endif
        end
    end

    assign Active = active_q;
    assign Up_Max = deb_q[UP];
    assign Dn_Max = deb_q[DN];

endmodule

// File: tb/tb_garage_input_conditioner.sv
module tb_garage_input_conditioner;

    localparam int DB = 4;
    localparam int TO = 20;
`ifdef GARAGE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn = 1'b0, up = 1'b0, dn = 1'b0;
    logic active, upm, dnm, fault;

    always #10 clk = ~clk;

    garage_input_conditioner #(
        .DB_CYCLES(DB),
        .TIMEOUT_CYCLES(TO),
        .TO_W(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .Btn_Raw(btn),
        .Up_Sw_Raw(up),
        .Dn_Sw_Raw(dn),
        .Active(active),
        .Up_Max(upm),
        .Dn_Max(dnm),
        .Fault(fault)
    );

    // Reference model: a level flips once the raw input has read the
    // opposite value on DB consecutive edges, counted from the edge two
    // before the current one (two synchroniser stages).
    logic [15:0] hist [3];  // bit k = raw sample k+1 edges ago
    logic [2:0]  m_lvl, m_prev;
    bit          m_act, m_flt;
    int          m_run;
    logic [3:0]  sb[$];
    int          total = 0, bad = 0, ncyc = 0;
    bit          seen = 0;

    task automatic model_step();
        logic [2:0] r;
        bit press, uh, dh, both, flip;
        r = {dn, up, btn};
        if (reset) begin
            for (int i = 0; i < 3; i++) hist[i] = '0;
            m_lvl = '0; m_prev = '0; m_act = 0; m_flt = 0; m_run = 0;
        end else begin
            press = m_lvl[0] & ~m_prev[0];
            uh    = m_lvl[1] & ~m_prev[1];
            dh    = m_lvl[2] & ~m_prev[2];
            both  = m_lvl[1] & m_lvl[2];
            if (m_act) begin
                if (press || uh || dh || both) m_act = 0;
                else if (TO_EN && m_run == TO - 1) begin m_act = 0; m_flt = 1; end
                m_run++;
            end else if (m_flt) begin
                if (press) m_flt = 0;
            end else if (press && !both) begin
                m_act = 1; m_run = 0;
            end
            m_prev = m_lvl;
            for (int i = 0; i < 3; i++) begin
                flip = 1;
                for (int k = 1; k <= DB; k++)
                    if (hist[i][k-1+1] == m_lvl[i]) flip = 0;
                if (flip) m_lvl[i] = ~m_lvl[i];
                hist[i] = {hist[i][14:0], r[i]};
            end
        end
        sb.push_back({m_act, m_lvl[1], m_lvl[2], m_flt});
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            model_step();
            seen = 1;
            #1;
        end
    endtask

    task automatic press_btn();
        btn = 1'b1; tick(7);
        btn = 1'b0; tick(8);
    endtask

    // Monitor: every cycle the DUT presents its four outputs; compare
    // against the oldest expected entry.
    initial begin
        logic [3:0] e, got;
        forever begin
            @(negedge clk);
            if (seen) begin
                ncyc++;
                total++;
                got = {active, upm, dnm, fault};
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL scoreboard_empty cyc=%0d got=%b", ncyc, got);
                end else begin
                    e = sb.pop_front();
                    if (got !== e) begin
                        bad++;
                        $display("FAIL outputs cyc=%0d got{Act,Up,Dn,Flt}=%b want=%b",
                                 ncyc, got, e);
                    end
                end
            end
        end
    end

    initial begin
        // 1: reset, then lower limit held
        reset = 1'b1; tick(3);
        reset = 1'b0; tick(2);
        dn = 1'b1; tick(10);
        // 2: short glitch on the button, then a stable press
        btn = 1'b1; tick(3);
        btn = 1'b0; tick(10);
        press_btn();
        tick(5);
        // 3: leave lower limit, reach upper limit during the run
        dn = 1'b0; tick(10);
        up = 1'b1; tick(12);
        // 4: start, user stop, restart
        press_btn();
        press_btn();
        press_btn();
        // 5: long run with no limit edge -> timeout when enabled
        tick(3 * TO);
        press_btn();
        press_btn();
        // 6: reset mid-run with a limit set
        reset = 1'b1; tick(1);
        reset = 1'b0; tick(10);
        // both limits together during a run
        up = 1'b0; dn = 1'b0; tick(8);
        press_btn();
        up = 1'b1; dn = 1'b1; tick(12);
        press_btn();
        up = 1'b0; dn = 1'b0; tick(10);
        // randomized phase
        for (int i = 0; i < 600; i++) begin
            btn = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) up = ~up;
            if ($urandom_range(0, 5) == 0) dn = ~dn;
            reset = ($urandom_range(0, 120) == 0);
            tick($urandom_range(1, 9));
            reset = 1'b0;
        end
        tick(2);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
